// File: rtl/dshot_pwm_output_pkg.sv
// dshot_pkg
//   Shared types and constants for the DShot-to-PWM output stage.
//   Contents:
//     dshot_pwm_state_t     supervision states (DISARMED, ARMING, ARMED, FAILSAFE)
//     DSHOT_MAX_SPEED       highest legal throttle value, larger inputs clamp to it
//     DSHOT_CMD_MOTOR_STOP  special command number meaning "motor stop"
//     DSHOT_3D_SPLIT        throttle value where the bidirectional mapping changes direction
//     clampSpeed()          saturates a raw 11-bit throttle to DSHOT_MAX_SPEED
package dshot_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAILSAFE = 2'd3
  } dshot_pwm_state_t;

  localparam int DSHOT_MAX_SPEED      = 1999;
  localparam int DSHOT_CMD_MOTOR_STOP = 0;
  localparam int DSHOT_3D_SPLIT       = 1000;

  // The decoder can hand us the full 11-bit range (up to 2047); anything
  // above the legal maximum is treated as full throttle.
  function automatic logic [10:0] clampSpeed(input logic [10:0] rawSpeed);
    if (rawSpeed > 11'(DSHOT_MAX_SPEED)) begin
      return 11'(DSHOT_MAX_SPEED);
    end
    return rawSpeed;
  endfunction

endpackage

// File: rtl/dshot_pwm_output_if.sv
// dshot_pwm_output_if
//   Decoded-frame bus from the DShot decoder to the PWM output stage.
//   Signals:
//     frame_valid  one-cycle strobe, the other fields hold a new decoded frame
//     set_speed    11-bit decoded throttle
//     is_special   frame carries a special command instead of a throttle
//     special_cmd  6-bit command number, meaningful when is_special is high
//     crc_valid    frame checksum matched
//   Modports:
//     master  decoder side, drives every field
//     slave   PWM output side, samples every field
interface dshot_pwm_output_if;

  logic        frame_valid;
  logic [10:0] set_speed;
  logic        is_special;
  logic [5:0]  special_cmd;
  logic        crc_valid;

  modport master (
    output frame_valid,
    output set_speed,
    output is_special,
    output special_cmd,
    output crc_valid
  );

  modport slave (
    input frame_valid,
    input set_speed,
    input is_special,
    input special_cmd,
    input crc_valid
  );

endinterface

// File: rtl/dshot_pwm_output_pwm_period_gen.sv
// pwm_period_gen
//   Free-running PWM period counter with an end-of-period width latch and a
//   registered pin driver. The width only changes on a period boundary, so the
//   pin never shows a runt or stretched pulse when the requested width moves.
//   Parameters:
//     PERIOD_CYC   period length in clk cycles (must fit in 16 bits)
//     IDLE_WIDTH   width loaded by reset
//   Ports:
//     clk          in   1   system clock
//     reset_n      in   1   synchronous, active-low reset
//     targetWidth  in   16  requested pulse width, sampled on the last cycle of a period
//     pulseWidth   out  16  width in effect for the current period
//     pwmOut       out  1   registered PWM pin
module pwm_period_gen #(
  parameter int          PERIOD_CYC = 40000,
  parameter logic [15:0] IDLE_WIDTH = 16'd16000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] targetWidth,
  output logic [15:0] pulseWidth,
  output logic        pwmOut
);

  localparam logic [15:0] LAST_COUNT = 16'(PERIOD_CYC - 1);

  logic [15:0] periodCnt;

  // Period counter, width latch and pin register share one block so they can
  // never drift apart. The pin is compared against the count before it
  // advances, which gives the pin a fixed one-cycle lag behind the counter.
  // A target that changes on the last cycle of a period misses this latch and
  // is picked up one period later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      periodCnt  <= '0;
      pulseWidth <= IDLE_WIDTH;
      pwmOut     <= 1'b0;
    end else begin
      pwmOut <= (periodCnt < pulseWidth);
      if (periodCnt == LAST_COUNT) begin
        periodCnt  <= '0;
        pulseWidth <= targetWidth;
      end else begin
        periodCnt <= periodCnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/dshot_pwm_output.sv
// dshot_pwm_output
//   Downstream stage of the DShot input decoder. Supervises arming and link
//   loss, turns accepted throttle frames into a pulse width and drives a
//   glitch-free, period-aligned ESC PWM pulse.
//   Parameters:
//     PERIOD_CYC   PWM period in clk cycles
//     MIN_CYC      pulse width for zero throttle / stop
//     STEP_CYC     cycles added per throttle LSB
//     ARM_FRAMES   consecutive stop frames needed to arm (2..255)
//     TIMEOUT_CYC  cycles without an accepted frame before the link is considered lost
//   Ports:
//     clk          in   1   system clock
//     reset_n      in   1   synchronous, active-low reset
//     frameBus     slave    decoded frames (dshot_pwm_output_if)
//     pwm_out      out  1   PWM pin
//     armed        out  1   supervision state is ARMED
//     failsafe     out  1   supervision state is FAILSAFE
//     pulse_width  out  16  width in effect for the current period
//     crc_err_cnt  out  8   saturating count of frames with a bad checksum
//   Build option:
//     DSHOT_PWM_3D_EN  when defined, throttle maps bidirectionally around the
//                      midpoint MIN_CYC + DSHOT_3D_SPLIT*STEP_CYC and every idle
//                      condition (stop, not armed, failsafe, reset) outputs the
//                      midpoint, so reset never commands full reverse. When
//                      undefined, the mapping is unidirectional from MIN_CYC.
module dshot_pwm_output
  import dshot_pkg::*;
#(
  parameter int PERIOD_CYC  = 40000,
  parameter int MIN_CYC     = 16000,
  parameter int STEP_CYC    = 8,
  parameter int ARM_FRAMES  = 10,
  parameter int TIMEOUT_CYC = 1600000
) (
  input  logic                clk,
  input  logic                reset_n,
  dshot_pwm_output_if.slave   frameBus,
  output logic                pwm_out,
  output logic                armed,
  output logic                failsafe,
  output logic [15:0]         pulse_width,
  output logic [7:0]          crc_err_cnt
);

`ifdef DSHOT_PWM_3D_EN
  localparam int IDLE_CYC = MIN_CYC + DSHOT_3D_SPLIT * STEP_CYC;
`else
  localparam int IDLE_CYC = MIN_CYC;
`endif

  localparam logic [15:0] IDLE_WIDTH = 16'(IDLE_CYC);
  localparam logic [7:0]  ARM_TARGET = 8'(ARM_FRAMES);
  localparam int          TO_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);

  // The widest pulse has to leave a low gap before the period ends, and the
  // 16-bit period counter has to be able to hold the period.
  if ((MIN_CYC + DSHOT_MAX_SPEED * STEP_CYC >= PERIOD_CYC) || (PERIOD_CYC >= 65536)) begin : gBadTiming
    $error("dshot_pwm_output: widest pulse must be shorter than PERIOD_CYC and PERIOD_CYC must fit in 16 bits");
  end

  if ((ARM_FRAMES < 2) || (ARM_FRAMES > 255)) begin : gBadArmFrames
    $error("dshot_pwm_output: ARM_FRAMES must lie in 2..255");
  end

  dshot_pwm_state_t state;
  logic [7:0]       armCnt;
  logic [7:0]       armCntInc;
  logic [TO_W-1:0]  timeoutCnt;
  logic [15:0]      targetWidth;
  logic [15:0]      speedWidth;
  logic [10:0]      speedClamped;
  logic             accepted;
  logic             stopFrame;
  logic             speedFrame;
  logic             crcError;
  logic             timeoutHit;

  // Frame classification. Special commands other than motor stop still count
  // as link activity through 'accepted' but otherwise change nothing.
  // The timeout fires on the cycle the idle counter would reach its limit,
  // so an accepted frame on that very cycle keeps the link alive.
  always_comb begin
    accepted   = frameBus.frame_valid && frameBus.crc_valid;
    stopFrame  = accepted && frameBus.is_special &&
                 (frameBus.special_cmd == 6'(DSHOT_CMD_MOTOR_STOP));
    speedFrame = accepted && !frameBus.is_special;
    crcError   = frameBus.frame_valid && !frameBus.crc_valid;
    timeoutHit = !accepted && (timeoutCnt >= TO_LAST);
    armCntInc  = armCnt + 8'd1;
  end

  // Throttle to pulse width.
  always_comb begin
    speedClamped = clampSpeed(frameBus.set_speed);
`ifdef DSHOT_PWM_3D_EN
    if (speedClamped < 11'(DSHOT_3D_SPLIT)) begin
      speedWidth = 16'(IDLE_CYC - int'(speedClamped) * STEP_CYC);
    end else begin
      speedWidth = 16'(IDLE_CYC + (int'(speedClamped) - DSHOT_3D_SPLIT) * STEP_CYC);
    end
`else
    speedWidth = 16'(MIN_CYC + int'(speedClamped) * STEP_CYC);
`endif
  end

  // Cycles since the last accepted frame; parks at the limit so a dead link
  // stays dead without the counter wrapping back into range.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timeoutCnt <= '0;
    end else if (accepted) begin
      timeoutCnt <= '0;
    end else if (timeoutCnt != TO_MAX) begin
      timeoutCnt <= timeoutCnt + 1'b1;
    end
  end

  // Bad-checksum frames are only counted; they neither feed the link timeout
  // nor the supervision logic.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc_err_cnt <= '0;
    end else if (crcError && (crc_err_cnt != 8'hFF)) begin
      crc_err_cnt <= crc_err_cnt + 8'd1;
    end
  end

  // Arm/failsafe supervision. armed and failsafe are registered alongside the
  // state so they always match it. Only ARMED lets a throttle frame through to
  // the target width; every other state holds the idle width.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= DISARMED;
      armCnt      <= '0;
      targetWidth <= IDLE_WIDTH;
      armed       <= 1'b0;
      failsafe    <= 1'b0;
    end else begin
      case (state)
        DISARMED: begin
          targetWidth <= IDLE_WIDTH;
          if (stopFrame) begin
            state  <= ARMING;
            armCnt <= 8'd1;
          end
        end
        ARMING: begin
          targetWidth <= IDLE_WIDTH;
          if (stopFrame) begin
            armCnt <= armCntInc;
            if (armCntInc == ARM_TARGET) begin
              state <= ARMED;
              armed <= 1'b1;
            end
          end else if (speedFrame || timeoutHit) begin
            state  <= DISARMED;
            armCnt <= '0;
          end
        end
        ARMED: begin
          if (timeoutHit) begin
            state       <= FAILSAFE;
            armed       <= 1'b0;
            failsafe    <= 1'b1;
            targetWidth <= IDLE_WIDTH;
          end else if (speedFrame) begin
            targetWidth <= speedWidth;
          end else if (stopFrame) begin
            targetWidth <= IDLE_WIDTH;
          end
        end
        FAILSAFE: begin
          targetWidth <= IDLE_WIDTH;
          if (stopFrame) begin
            state    <= ARMING;
            armCnt   <= 8'd1;
            failsafe <= 1'b0;
          end
        end
        default: begin
          state       <= DISARMED;
          armCnt      <= '0;
          targetWidth <= IDLE_WIDTH;
          armed       <= 1'b0;
          failsafe    <= 1'b0;
        end
      endcase
    end
  end

  pwm_period_gen #(
    .PERIOD_CYC (PERIOD_CYC),
    .IDLE_WIDTH (IDLE_WIDTH)
  ) periodGen (
    .clk         (clk),
    .reset_n     (reset_n),
    .targetWidth (targetWidth),
    .pulseWidth  (pulse_width),
    .pwmOut      (pwm_out)
  );

endmodule

// File: tb/tb_dshot_pwm_output.sv
// tb_dshot_pwm_output
//   Self-checking bench for dshot_pwm_output with scaled-down timing so every
//   scenario fits in a short run. Expected pulse widths are queued when frames
//   are driven and compared against pulses measured on the pin.
module tb_dshot_pwm_output;

  localparam int PERIOD = 2100;
  localparam int MINW   = 60;
  localparam int STEP   = 1;
  localparam int ARMN   = 10;
  localparam int TMO    = 5000;
  localparam int WAIT_LIMIT = 2 * PERIOD + 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pwm_out;
  logic        armed;
  logic        failsafe;
  logic [15:0] pulse_width;
  logic [7:0]  crc_err_cnt;

  int checks = 0;
  int errors = 0;
  int expectedQ[$];
  int measuredQ[$];
  int runLen = 0;

  dshot_pwm_output_if frameIf ();

  dshot_pwm_output #(
    .PERIOD_CYC  (PERIOD),
    .MIN_CYC     (MINW),
    .STEP_CYC    (STEP),
    .ARM_FRAMES  (ARMN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frameBus    (frameIf),
    .pwm_out     (pwm_out),
    .armed       (armed),
    .failsafe    (failsafe),
    .pulse_width (pulse_width),
    .crc_err_cnt (crc_err_cnt)
  );

  always #5 clk = ~clk;

  // Pulse monitor: measures each high run on the pin at the falling clock edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      runLen = 0;
    end else if (pwm_out) begin
      runLen++;
    end else if (runLen > 0) begin
      measuredQ.push_back(runLen);
      runLen = 0;
    end
  end

  task automatic applyStimulus(input logic [10:0] speed, input logic special,
                               input logic [5:0] cmd, input logic crc);
    @(negedge clk);
    frameIf.frame_valid = 1'b1;
    frameIf.set_speed   = speed;
    frameIf.is_special  = special;
    frameIf.special_cmd = cmd;
    frameIf.crc_valid   = crc;
    @(negedge clk);
    frameIf.frame_valid = 1'b0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset_n = 1'b0;
    frameIf.frame_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    expectedQ.delete();
    measuredQ.delete();
  endtask

  task automatic waitRise(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = pwm_out;
    for (int i = 0; i < WAIT_LIMIT && !ok; i++) begin
      @(posedge clk);
      #1;
      if (pwm_out && !prev) ok = 1'b1;
      prev = pwm_out;
    end
  endtask

  task automatic waitPulse(output int width, output bit ok);
    ok = 1'b0;
    width = 0;
    for (int i = 0; i < WAIT_LIMIT && measuredQ.size() == 0; i++) begin
      @(posedge clk);
    end
    if (measuredQ.size() > 0) begin
      width = measuredQ.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int got, exp, cyc;
    logic prev;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwm got %b required 0", pwm_out); end
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL reset_armed got %b required 0", armed); end
    checks++; if (failsafe !== 1'b0) begin errors++; $display("[TB] FAIL reset_failsafe got %b required 0", failsafe); end
    checks++; if (pulse_width !== 16'(MINW)) begin errors++; $display("[TB] FAIL reset_width got %0d required %0d", pulse_width, MINW); end
    checks++; if (crc_err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_crc got %0d required 0", crc_err_cnt); end
    @(negedge clk);
    reset_n = 1'b1;
    waitRise(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL reset_align no rising edge, required one within %0d cycles", WAIT_LIMIT); end
    expectedQ.delete(); measuredQ.delete();
    expectedQ.push_back(MINW);
    expectedQ.push_back(MINW);
    cyc = 0;
    prev = 1'b1;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pwm_out && !prev) break;
      prev = pwm_out;
    end
    checks++; if (cyc !== PERIOD) begin errors++; $display("[TB] FAIL reset_period got %0d required %0d", cyc, PERIOD); end
    while (expectedQ.size() > 0) begin
      exp = expectedQ.pop_front();
      waitPulse(got, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL reset_width_pulse timeout, required %0d", exp); end
      else if (got !== exp) begin errors++; $display("[TB] FAIL reset_width_pulse got %0d required %0d", got, exp); end
    end
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL idle_armed got %b required 0", armed); end
  endtask

  task automatic test_arm();
    bit ok;
    int got, exp;
    resetDut();
    waitRise(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL arm_align no rising edge within %0d cycles", WAIT_LIMIT); end
    expectedQ.delete(); measuredQ.delete();
    expectedQ.push_back(MINW);
    for (int i = 0; i < ARMN; i++) begin
      applyStimulus(11'd0, 1'b1, 6'd0, 1'b1);
      if (i == ARMN - 2) begin
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL arm_early got %b required 0", armed); end
      end
    end
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL arm_done got %b required 1", armed); end
    applyStimulus(11'd1999, 1'b0, 6'd0, 1'b1);
    expectedQ.push_back(MINW + 1999 * STEP);
    while (expectedQ.size() > 0) begin
      exp = expectedQ.pop_front();
      waitPulse(got, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL arm_pulse timeout, required %0d", exp); end
      else if (got !== exp) begin errors++; $display("[TB] FAIL arm_pulse got %0d required %0d", got, exp); end
    end
    checks++; if (pulse_width !== 16'(MINW + 1999 * STEP)) begin errors++; $display("[TB] FAIL arm_width got %0d required %0d", pulse_width, MINW + 1999 * STEP); end
  endtask

  task automatic test_arming_interrupt();
    bit ok;
    int got, exp;
    resetDut();
    waitRise(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL intr_align no rising edge within %0d cycles", WAIT_LIMIT); end
    expectedQ.delete(); measuredQ.delete();
    expectedQ.push_back(MINW);
    for (int i = 0; i < 5; i++) applyStimulus(11'd0, 1'b1, 6'd0, 1'b1);
    applyStimulus(11'd500, 1'b0, 6'd0, 1'b1);
    for (int i = 0; i < ARMN; i++) begin
      applyStimulus(11'd0, 1'b1, 6'd0, 1'b1);
      if (i == ARMN - 2) begin
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL intr_14th got %b required 0", armed); end
      end
    end
    checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL intr_15th got %b required 1", armed); end
    expectedQ.push_back(MINW);
    while (expectedQ.size() > 0) begin
      exp = expectedQ.pop_front();
      waitPulse(got, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL intr_pulse timeout, required %0d", exp); end
      else if (got !== exp) begin errors++; $display("[TB] FAIL intr_pulse got %0d required %0d", got, exp); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int got, exp, cyc;
    resetDut();
    waitRise(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL tmo_align no rising edge within %0d cycles", WAIT_LIMIT); end
    for (int i = 0; i < ARMN; i++) applyStimulus(11'd0, 1'b1, 6'd0, 1'b1);
    applyStimulus(11'd1000, 1'b0, 6'd0, 1'b1);
    cyc = 0;
    for (int i = 0; i < TMO + 20; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == PERIOD + 200) begin
        checks++; if (pulse_width !== 16'(MINW + 1000 * STEP)) begin errors++; $display("[TB] FAIL tmo_width_armed got %0d required %0d", pulse_width, MINW + 1000 * STEP); end
      end
      if (failsafe === 1'b1) break;
    end
    checks++; if (cyc !== TMO) begin errors++; $display("[TB] FAIL tmo_latency got %0d required %0d", cyc, TMO); end
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL tmo_armed got %b required 0", armed); end
    checks++; if (failsafe !== 1'b1) begin errors++; $display("[TB] FAIL tmo_failsafe got %b required 1", failsafe); end
    waitRise(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL tmo_align2 no rising edge within %0d cycles", WAIT_LIMIT); end
    expectedQ.delete(); measuredQ.delete();
    expectedQ.push_back(MINW);
    applyStimulus(11'd1999, 1'b0, 6'd0, 1'b1);
    expectedQ.push_back(MINW);
    while (expectedQ.size() > 0) begin
      exp = expectedQ.pop_front();
      waitPulse(got, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL tmo_pulse timeout, required %0d", exp); end
      else if (got !== exp) begin errors++; $display("[TB] FAIL tmo_pulse got %0d required %0d", got, exp); end
    end
    applyStimulus(11'd0, 1'b1, 6'd0, 1'b1);
    checks++; if (failsafe !== 1'b0) begin errors++; $display("[TB] FAIL tmo_rearm_failsafe got %b required 0", failsafe); end
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL tmo_rearm_armed got %b required 0", armed); end
  endtask

  task automatic test_crc();
    bit ok;
    int got, exp;
    resetDut();
    waitRise(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL crc_align no rising edge within %0d cycles", WAIT_LIMIT); end
    expectedQ.delete(); measuredQ.delete();
    expectedQ.push_back(MINW);
    for (int i = 0; i < ARMN; i++) applyStimulus(11'd0, 1'b1, 6'd0, 1'b1);
    applyStimulus(11'd700, 1'b0, 6'd0, 1'b1);
    expectedQ.push_back(MINW + 700 * STEP);
    for (int i = 0; i < 3; i++) applyStimulus(11'd1999, 1'b0, 6'd0, 1'b0);
    expectedQ.push_back(MINW + 700 * STEP);
    while (expectedQ.size() > 0) begin
      exp = expectedQ.pop_front();
      waitPulse(got, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL crc_pulse timeout, required %0d", exp); end
      else if (got !== exp) begin errors++; $display("[TB] FAIL crc_pulse got %0d required %0d", got, exp); end
    end
    checks++; if (crc_err_cnt !== 8'd3) begin errors++; $display("[TB] FAIL crc_count3 got %0d required 3", crc_err_cnt); end
    for (int i = 0; i < 251; i++) applyStimulus(11'd5, 1'b0, 6'd0, 1'b0);
    checks++; if (crc_err_cnt !== 8'd254) begin errors++; $display("[TB] FAIL crc_count254 got %0d required 254", crc_err_cnt); end
    for (int i = 0; i < 46; i++) applyStimulus(11'd5, 1'b0, 6'd0, 1'b0);
    checks++; if (crc_err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL crc_saturate got %0d required 255", crc_err_cnt); end
  endtask

  task automatic test_boundary();
    bit ok;
    int got, exp;
    resetDut();
    waitRise(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bnd_align no rising edge within %0d cycles", WAIT_LIMIT); end
    for (int i = 0; i < ARMN; i++) applyStimulus(11'd0, 1'b1, 6'd0, 1'b1);
    applyStimulus(11'd500, 1'b0, 6'd0, 1'b1);
    waitRise(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bnd_align2 no rising edge within %0d cycles", WAIT_LIMIT); end
    expectedQ.delete(); measuredQ.delete();
    expectedQ.push_back(MINW + 500 * STEP);
    repeat (PERIOD - 2) @(posedge clk);
    applyStimulus(11'd2047, 1'b0, 6'd0, 1'b1);
    expectedQ.push_back(MINW + 500 * STEP);
    expectedQ.push_back(MINW + 1999 * STEP);
    @(posedge clk);
    #1;
    checks++; if (pulse_width !== 16'(MINW + 500 * STEP)) begin errors++; $display("[TB] FAIL bnd_old_width got %0d required %0d", pulse_width, MINW + 500 * STEP); end
    repeat (PERIOD) @(posedge clk);
    #1;
    checks++; if (pulse_width !== 16'(MINW + 1999 * STEP)) begin errors++; $display("[TB] FAIL bnd_new_width got %0d required %0d", pulse_width, MINW + 1999 * STEP); end
    while (expectedQ.size() > 0) begin
      exp = expectedQ.pop_front();
      waitPulse(got, ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL bnd_pulse timeout, required %0d", exp); end
      else if (got !== exp) begin errors++; $display("[TB] FAIL bnd_pulse got %0d required %0d", got, exp); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    bit ok;
    waitRise(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_align no rising edge within %0d cycles", WAIT_LIMIT); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_pwm got %b required 0", pwm_out); end
    checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL mid_armed got %b required 0", armed); end
    checks++; if (pulse_width !== 16'(MINW)) begin errors++; $display("[TB] FAIL mid_width got %0d required %0d", pulse_width, MINW); end
    @(negedge clk);
    reset_n = 1'b1;
    expectedQ.delete(); measuredQ.delete();
  endtask

  // Scenario sequence; each task drives its own stimulus and checks inline.
  initial begin
    reset_n = 1'b0;
    frameIf.frame_valid = 1'b0;
    frameIf.set_speed   = '0;
    frameIf.is_special  = 1'b0;
    frameIf.special_cmd = '0;
    frameIf.crc_valid   = 1'b0;
    test_reset();
    test_arm();
    test_arming_interrupt();
    test_timeout();
    test_crc();
    test_boundary();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
